// File: rtl/led7_pkg.sv
// Shared constants and helpers for the multiplexed seven-segment scanner.
package led7_pkg;

  localparam int              SEG_W   = 8;
  localparam logic [SEG_W-1:0] SEG_OFF = 8'h00;

  // One-hot enable for digit idx. Returns zero when idx is not a valid digit.
  function automatic logic [31:0] onehot(input logic [31:0] idx, input int count);
    logic [31:0] r;
    r = '0;
    if (idx < 32'(count)) r[idx[4:0]] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/led7_scan_counter.sv
// Modulo-MOD up-counter with enable. wrap_o is high on an enabled cycle in which
// the counter sits at its last value and will return to zero on the next edge.
module mod_counter #(
  parameter int MOD = 4,
  localparam int W = (MOD > 1) ? $clog2(MOD) : 1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         en_i,
  output logic [W-1:0] cnt_o,
  output logic         wrap_o
);

  localparam logic [W-1:0] LAST = W'(MOD - 1);

  logic [W-1:0] cnt_q, cnt_d;
  logic         at_last;

  assign at_last = (cnt_q == LAST);
  assign wrap_o  = en_i && at_last;
  assign cnt_o   = cnt_q;

  // Next count: advance when enabled, fold back to zero after the last value.
  always_comb begin
    cnt_d = cnt_q;
    if (en_i) cnt_d = at_last ? '0 : cnt_q + 1'b1;
  end

  // Count register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/led7_scan.sv
// Time-multiplexed seven-segment driver. Scans a per-digit segment bus onto one
// shared segment bus with one-hot digit enables. The input is captured once per
// frame so a digit never shows a half-updated pattern, and the first cycles of
// each slot keep every digit off so the previous pattern cannot ghost.
module led7_scan
  import led7_pkg::*;
#(
  parameter int COUNT        = 6,
  parameter int CLK_DIV      = 1000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic [COUNT*SEG_W-1:0] leds,
  output logic [SEG_W-1:0]       seg,
  output logic [COUNT-1:0]       dig,
  output logic                   frame_tick
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IDX_W = (COUNT > 1) ? $clog2(COUNT) : 1;

  logic [CNT_W-1:0]       cnt;
  logic [IDX_W-1:0]       idx;
  logic                   slot_wrap;
  logic                   frame_wrap;
  logic                   blank_ok;
  logic [31:0]            oh_full;

  logic [COUNT*SEG_W-1:0] shadow_q, shadow_d;
  logic [SEG_W-1:0]       seg_q, seg_d;
  logic [COUNT-1:0]       dig_q, dig_d;
  logic                   tick_q, tick_d;

  mod_counter #(.MOD(CLK_DIV)) u_slot_cnt (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .en_i   (en),
    .cnt_o  (cnt),
    .wrap_o (slot_wrap)
  );

  // The digit counter only steps on the last cycle of a slot, so its own wrap
  // marks the final cycle of the frame: that is when a new snapshot is taken.
  mod_counter #(.MOD(COUNT)) u_digit_cnt (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .en_i   (en && slot_wrap),
    .cnt_o  (idx),
    .wrap_o (frame_wrap)
  );

  if (BLANK_CYCLES == 0) begin : g_no_blank
    assign blank_ok = 1'b1;
  end else begin : g_blank
    localparam logic [CNT_W-1:0] BLANK_L = CNT_W'(BLANK_CYCLES);
    assign blank_ok = (cnt >= BLANK_L);
  end

  assign oh_full = onehot(32'(idx), COUNT);

  if (COUNT < 32) begin : g_unused_oh
    logic unused_oh;
    assign unused_oh = ^oh_full[31:COUNT];
  end

  // Next snapshot, output byte, digit enable and frame pulse from pre-edge state.
  always_comb begin
    shadow_d = shadow_q;
    if (frame_wrap) shadow_d = leds;

    seg_d = SEG_OFF;
    for (int i = 0; i < COUNT; i++) begin
      if (idx == IDX_W'(i)) seg_d = shadow_q[SEG_W*i +: SEG_W];
    end

    dig_d = '0;
    if (en && blank_ok) dig_d = oh_full[COUNT-1:0];

    tick_d = frame_wrap;
  end

  // Snapshot and output registers; reset clears the display immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= '0;
      seg_q    <= SEG_OFF;
      dig_q    <= '0;
      tick_q   <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      seg_q    <= seg_d;
      dig_q    <= dig_d;
      tick_q   <= tick_d;
    end
  end

  assign seg        = seg_q;
  assign dig        = dig_q;
  assign frame_tick = tick_q;

endmodule
